// File: rtl/divide_pkg.sv
// Shared constants and state encoding for the sequential signed divider.
package divide_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ITERS  = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10
  } state_e;

endpackage

// File: rtl/absolute.sv
// 16-bit absolute value; |0x8000| stays 0x8000 and is read as unsigned 32768.
module absolute
  import divide_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  output logic [DATA_W-1:0] y_o
);

  logic [DATA_W-1:0] neg_c;

  multiply_minus_one u_neg (
    .a_i (a_i),
    .y_o (neg_c)
  );

  assign y_o = a_i[DATA_W-1] ? neg_c : a_i;

endmodule

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on the {rem, quo} pair.
module div_step
  import divide_pkg::*;
(
  input  logic [DATA_W:0]   rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W:0]   rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted_c;
  logic [DATA_W:0] diff_c;
  logic            ge_c;
  logic            unused_rem_msb;

  // Partial remainder stays below |B| <= 32768, so its top bit never shifts out.
  assign unused_rem_msb = rem_i[DATA_W];

  // Shift in the next dividend bit, then subtract when it fits.
  always_comb begin
    shifted_c = {rem_i[DATA_W-1:0], quo_i[DATA_W-1]};
    diff_c    = shifted_c - {1'b0, divisor_i};
    ge_c      = (shifted_c >= {1'b0, divisor_i});
    rem_o     = ge_c ? diff_c : shifted_c;
    quo_o     = {quo_i[DATA_W-2:0], ge_c};
  end

endmodule

// File: rtl/multiply_minus_one.sv
// Two's-complement negation of a 16-bit word (0x8000 maps to itself).
module multiply_minus_one
  import divide_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  output logic [DATA_W-1:0] y_o
);

  assign y_o = ~a_i + DATA_W'(1);

endmodule

// File: rtl/divide.sv
// Sequential signed 16-bit divider: magnitudes, 16 restoring steps, sign fix-up.
module divide
  import divide_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] Q,
  output logic [DATA_W-1:0] R,
  output logic              div_zero
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              zero_q, zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic              dz_q, dz_d;

  logic [DATA_W-1:0] abs_a_c, abs_b_c;
  logic [DATA_W-1:0] quo_neg_c, rem_neg_c;
  logic [DATA_W:0]   step_rem_c;
  logic [DATA_W-1:0] step_quo_c;

  absolute u_abs_a (.a_i(A), .y_o(abs_a_c));
  absolute u_abs_b (.a_i(B), .y_o(abs_b_c));

  multiply_minus_one u_neg_quo (.a_i(quo_q),              .y_o(quo_neg_c));
  multiply_minus_one u_neg_rem (.a_i(rem_q[DATA_W-1:0]),  .y_o(rem_neg_c));

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem_c),
    .quo_o     (step_quo_c)
  );

  // Next-state, datapath and output register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    q_d      = q_q;
    r_d      = r_q;
    dz_d     = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_a_d = A[DATA_W-1];
          sign_b_d = B[DATA_W-1];
          quo_d    = abs_a_c;
          dvs_d    = abs_b_c;
          zero_d   = (B == '0);
          a_d      = A;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem_c;
        quo_d = step_quo_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        done_d = 1'b1;
        dz_d   = zero_q;
        if (zero_q) begin
          q_d = '0;
          r_d = a_q;
        end else begin
          q_d = (sign_a_q ^ sign_b_q) ? quo_neg_c : quo_q;
          r_d = sign_a_q ? rem_neg_c : rem_q[DATA_W-1:0];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == SIGN);
  end

  // State and output registers with asynchronous abort.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      q_q      <= '0;
      r_q      <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      q_q      <= q_d;
      r_q      <= r_d;
      dz_q     <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Q        = q_q;
  assign R        = r_q;
  assign div_zero = dz_q;

endmodule

// File: doc/divide.md
# divide

Sequential signed 16-bit two's-complement divider producing quotient and remainder. It is the inverse operation of the ALU's combinational signed multiplier and sits beside it in the arithmetic datapath. It converts operands to magnitudes, runs a 16-iteration restoring shift-subtract loop, then restores signs. A start/done handshake gives fixed latency.

## Interface
- Parameters: none. Width is fixed at 16 to match the multiplier datapath.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  operand-valid strobe; sampled only in IDLE
- `A`  in  16  dividend, signed two's complement
- `B`  in  16  divisor, signed two's complement
- `busy`  out  1  high while a division is in flight (CALC, SIGN)
- `done`  out  1  one-cycle pulse; `Q`/`R`/`div_zero` valid from this cycle on
- `Q`  out  16  quotient, signed
- `R`  out  16  remainder, signed
- `div_zero`  out  1  the last completed operation had B = 0

## Operation
- States:
  - IDLE: start=1 latches sign(A), sign(B), |A|, |B| and whether B==0. Clears the 17-bit partial remainder. Clears the iteration counter. Goes to CALC.
  - CALC: one restoring step per cycle. Shift the {rem, quo} pair left by 1. Compare rem against |B|. If rem >= |B|, subtract and set the quotient LSB. Repeat for 16 steps, then go to SIGN.
  - SIGN: apply signs, register Q/R/div_zero, pulse done, go to IDLE.
- Sign rules (truncation toward zero):
  - Q is negated when A[15] xor B[15].
  - R takes the sign of A.
  - Check: |R| < |B| and A = Q·B + R.
- Magnitudes are taken on 16 bits. |−32768| = 0x8000 is treated as unsigned 32768 in the loop.
- Overflow: −32768 / −1 wraps to Q = 0x8000, R = 0, with no flag. This matches the multiplier's truncating behaviour.
- Divide by zero: same fixed latency. Q = 0x0000, R = A, div_zero = 1. The loop result is discarded.
- start while busy is ignored; operands are not re-sampled.
- A, B may change freely after the start cycle.
- Q, R and div_zero hold their values until the next SIGN state overwrites them.

## Timing
- Reset values: busy=0, done=0, Q=0x0000, R=0x0000, div_zero=0, state=IDLE.
- Let start be sampled high at edge k:
  - busy is high after edges k … k+16.
  - The CALC iterations occur at edges k+1 … k+16.
  - SIGN registers outputs at edge k+17.
  - done=1, busy=0 for exactly the cycle after edge k+17.
- Latency is 17 cycles start-to-done.
- Back-to-back: start high during the done cycle is accepted. The next done follows 17 cycles later.
- Reset asserted mid-operation aborts the operation immediately (asynchronous):
  - All outputs return to reset values.
  - No done pulse is produced for the aborted operation.
- done is never high together with busy.

## Structure
- A shared package holds:
  - the data width constant, 16
  - the iteration count, 16
  - the state encoding: IDLE=2'b00, CALC=2'b01, SIGN=2'b10
- Sign handling reuses the existing 16-bit `absolute` and `multiply_minus_one` modules; no new negation logic is written.
- One natural sub-module: `div_step`. It is combinational and takes the 17-bit rem, 16-bit quo and 16-bit divisor. It returns the next rem and quo. It is instantiated once inside the sequential loop.
- The FSM, counter and output registers stay in `divide`.

## Test plan
- A=100, B=7, start pulse -> done exactly 17 cycles later, Q=0x000E, R=0x0002, div_zero=0; busy high for the 17 cycles before.
- A=−100 (0xFF9C), B=7 -> Q=0xFFF2 (−14), R=0xFFFE (−2). Then A=100, B=−7 -> Q=0xFFF2, R=0x0002.
- A=0x8000, B=0xFFFF -> Q=0x8000, R=0x0000. Then A=0x8000, B=0x0001 -> Q=0x8000, R=0.
- A=5, B=0 -> done at cycle 17, Q=0x0000, R=0x0005, div_zero=1. Next op 9/3 -> Q=3, R=0, div_zero=0.
- Start 1000/10, pulse reset at CALC iteration 8 -> busy/Q/R drop to 0 immediately, no done. Then start 1000/10 -> Q=100, R=0.
- Start 50/5, hold start high through busy, re-assert start in the done cycle with 51/5:
  - first result Q=10, R=0
  - second done 17 cycles later, Q=10, R=1
  - no extra done pulses
